// File: rtl/mac_array_pipe_if.sv
// rtl/mac_array_pipe_if.sv - control, beat and result signals of the multi-lane MAC engine
interface mac_array_pipe_if #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int AW    = 16
);
    logic                  start;
    logic [LANES*DW-1:0]   BIAS_IN;
    logic [LANES*DW-1:0]   a_in;
    logic [DW-1:0]         b_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*AW-1:0]   acc_out;
    logic [LANES*DW-1:0]   q_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    modport master (
        output start, BIAS_IN, a_in, b_in, in_valid, out_ready,
        input  in_ready, acc_out, q_out, out_valid, busy
    );

    modport slave (
        input  start, BIAS_IN, a_in, b_in, in_valid, out_ready,
        output in_ready, acc_out, q_out, out_valid, busy
    );
endinterface

// File: rtl/mac_array_pipe.sv
// rtl/mac_array_pipe.sv - multi-lane signed MAC with broadcast weight, saturating accumulate and requantised output
module mac_array_pipe #(
    parameter int LANES      = 4,
    parameter int DW         = 8,
    parameter int AW         = 16,
    parameter int BIAS_SHIFT = 4,
    parameter int TAPS       = 9,
    parameter int OUT_SHIFT  = 8
) (
    input  logic              CLKEXT,
    input  logic              reset,
    mac_array_pipe_if.slave   bus
);
    localparam logic [7:0] TAPS_C = 8'(TAPS);
    localparam int         QMAX   = (1 << (DW - 1)) - 1;
    localparam int         QMIN   = -(1 << (DW - 1));

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                  state;
    logic [7:0]              count;
    logic                    p_valid;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    busy_r;
    logic signed [2*DW-1:0]  prod     [LANES];
    logic signed [AW-1:0]    acc      [LANES];
    logic signed [DW-1:0]    q        [LANES];
    logic signed [AW-1:0]    acc_sum  [LANES];
    logic signed [AW-1:0]    acc_bias [LANES];

    // One guard bit is enough: the top two bits disagree only on overflow.
    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                     input logic signed [2*DW-1:0] p);
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(p);
        case (s[AW:AW-1])
            2'b01:   return {1'b0, {(AW-1){1'b1}}};
            2'b10:   return {1'b1, {(AW-1){1'b0}}};
            default: return s[AW-1:0];
        endcase
    endfunction

    function automatic logic signed [DW-1:0] requant(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > AW'(QMAX))      return DW'(QMAX);
        else if (s < AW'(QMIN)) return DW'(QMIN);
        else                    return s[DW-1:0];
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            acc_bias[l] = AW'($signed(bus.BIAS_IN[l*DW +: DW])) <<< BIAS_SHIFT;
            acc_sum[l]  = sat_add(acc[l], prod[l]);
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 8'd0;
            p_valid     <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
                q[l]    <= '0;
            end
        end else begin
            p_valid <= 1'b0;
            // The last product lands during DRAIN, so this never collides with a bias load.
            if (p_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    acc[l] <= acc_sum[l];
                    q[l]   <= requant(acc_sum[l]);
                end
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= ACCUM;
                        count      <= 8'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        for (int l = 0; l < LANES; l++) begin
                            acc[l] <= acc_bias[l];
                            q[l]   <= requant(acc_bias[l]);
                        end
                    end
                end
                ACCUM: begin
                    if (bus.in_valid && in_ready_r) begin
                        for (int l = 0; l < LANES; l++)
                            prod[l] <= (2*DW)'($signed(bus.a_in[l*DW +: DW])) *
                                       (2*DW)'($signed(bus.b_in));
                        p_valid <= 1'b1;
                        count   <= count + 8'd1;
                        if (count + 8'd1 == TAPS_C) begin
                            state      <= DRAIN;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state       <= HOLD;
                    out_valid_r <= 1'b1;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.acc_out = '0;
        bus.q_out   = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.acc_out[l*AW +: AW] = acc[l];
            bus.q_out[l*DW +: DW]   = q[l];
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mac_array_pipe.sv
// tb/tb_mac_array_pipe.sv - randomized self-checking bench for mac_array_pipe against an arithmetic model
module tb_mac_array_pipe;
    localparam int LANES = 4, DW = 8, AW = 16, BIAS_SHIFT = 4, TAPS = 9, OUT_SHIFT = 8;

    logic CLKEXT = 1'b0;
    logic reset  = 1'b1;
    always #5 CLKEXT = ~CLKEXT;

    mac_array_pipe_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

    mac_array_pipe #(
        .LANES(LANES), .DW(DW), .AW(AW), .BIAS_SHIFT(BIAS_SHIFT), .TAPS(TAPS), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .CLKEXT (CLKEXT),
        .reset  (reset),
        .bus    (bus)
    );

    int n_checks = 0, n_fail = 0, cyc = 0;
    int op_a [TAPS][LANES];
    int op_b [TAPS];
    int bias [LANES];
    int exp_acc [LANES];
    int exp_q   [LANES];
    bit exp_valid = 1'b0, done_flag = 1'b0, prev_ov = 1'b0;
    int done_cyc = 0, last_acc_cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Result = bias*2^BIAS_SHIFT plus each product, clamped to AW bits after every beat.
    function automatic void compute_model();
        for (int l = 0; l < LANES; l++) begin
            int s;
            s = bias[l] * (1 << BIAS_SHIFT);
            for (int t = 0; t < TAPS; t++)
                s = clamp(s + op_a[t][l] * op_b[t], -(1 << (AW-1)), (1 << (AW-1)) - 1);
            exp_acc[l] = s;
            exp_q[l]   = clamp(s >>> OUT_SHIFT, -(1 << (DW-1)), (1 << (DW-1)) - 1);
        end
    endfunction

    task automatic fill_const(input int b0, input int av, input int bv);
        for (int l = 0; l < LANES; l++) bias[l] = b0;
        for (int t = 0; t < TAPS; t++) begin
            op_b[t] = bv;
            for (int l = 0; l < LANES; l++) op_a[t][l] = av;
        end
    endtask

    task automatic fill_rand();
        for (int l = 0; l < LANES; l++) bias[l] = int'($urandom_range(0, 255)) - 128;
        for (int t = 0; t < TAPS; t++) begin
            op_b[t] = int'($urandom_range(0, 255)) - 128;
            for (int l = 0; l < LANES; l++) op_a[t][l] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Compare process: sample a little after each active edge.
    always begin
        @(posedge CLKEXT);
        #2;
        cyc++;
        if (reset) begin
            chk("rst_acc_out", int'(bus.acc_out != '0), 0);
            chk("rst_q_out", int'(bus.q_out != '0), 0);
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_in_ready", int'(bus.in_ready), 0);
            chk("rst_busy", int'(bus.busy), 0);
        end else begin
            if (bus.out_valid && !prev_ov) begin
                chk("latency", cyc, last_acc_cyc + 2);
                chk("result_expected", int'(exp_valid), 1);
            end
            if (prev_ov && bus.out_ready) begin
                chk("out_valid_fall", int'(bus.out_valid), 0);
                chk("busy_fall", int'(bus.busy), 0);
            end else if (prev_ov) begin
                chk("out_valid_hold", int'(bus.out_valid), 1);
            end
            if (bus.out_valid && exp_valid) begin
                for (int l = 0; l < LANES; l++) begin
                    chk($sformatf("acc_lane%0d", l), int'($signed(bus.acc_out[l*AW +: AW])), exp_acc[l]);
                    chk($sformatf("q_lane%0d", l), int'($signed(bus.q_out[l*DW +: DW])), exp_q[l]);
                end
                chk("busy_in_hold", int'(bus.busy), 1);
            end
            if (done_flag && cyc > done_cyc) chk("in_ready_low_after_taps", int'(bus.in_ready), 0);
        end
        prev_ov = bus.out_valid;
    end

    task automatic run_op(input bit bubbles, input int hold_low, input bit pulses, input int abort_at);
        int  k, budget, held;
        bit  hs, rdy, v;
        @(negedge CLKEXT);
        exp_valid     = 1'b0;
        done_flag     = 1'b0;
        bus.start     = 1'b1;
        for (int l = 0; l < LANES; l++) bus.BIAS_IN[l*DW +: DW] = DW'(bias[l]);
        bus.in_valid  = 1'b1;
        bus.a_in      = (LANES*DW)'($urandom);
        bus.b_in      = DW'($urandom);
        bus.out_ready = 1'b0;
        k = 0;
        budget = 0;
        while (k < TAPS && budget < 200) begin
            @(negedge CLKEXT);
            rdy          = bus.in_ready;
            v            = bubbles ? (budget % 2 == 1) : ($urandom_range(0, 3) != 0);
            bus.start    = pulses && (budget == 3);
            bus.BIAS_IN  = (LANES*DW)'($urandom);
            bus.in_valid = v;
            if (v) begin
                for (int l = 0; l < LANES; l++) bus.a_in[l*DW +: DW] = DW'(op_a[k][l]);
                bus.b_in = DW'(op_b[k]);
            end else begin
                bus.a_in = (LANES*DW)'($urandom);
                bus.b_in = DW'($urandom);
            end
            if (v && rdy) begin
                last_acc_cyc = cyc;
                k++;
                if (k == TAPS) begin
                    compute_model();
                    exp_valid = 1'b1;
                    done_flag = 1'b1;
                    done_cyc  = cyc;
                end
            end
            budget++;
            if (abort_at > 0 && k == abort_at) begin
                @(negedge CLKEXT);
                reset        = 1'b1;
                bus.in_valid = 1'b0;
                bus.start    = 1'b0;
                @(negedge CLKEXT);
                reset = 1'b0;
                return;
            end
        end
        if (k < TAPS) chk("beat_timeout", k, TAPS);
        held = 0;
        hs = 1'b0;
        budget = 0;
        while (!hs && budget < 100) begin
            @(negedge CLKEXT);
            bus.in_valid = 1'b1;
            bus.a_in     = (LANES*DW)'($urandom);
            bus.b_in     = DW'($urandom);
            bus.BIAS_IN  = (LANES*DW)'($urandom);
            bus.start    = 1'b0;
            if (bus.out_valid) begin
                if (held >= hold_low) begin
                    bus.out_ready = 1'b1;
                    hs = 1'b1;
                end else begin
                    bus.out_ready = 1'b0;
                    bus.start     = pulses;
                end
                held++;
            end
            budget++;
        end
        if (!hs) chk("out_timeout", 0, 1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.BIAS_IN   = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge CLKEXT);
        reset = 1'b0;

        fill_const(1, 2, 3);
        compute_model();
        chk("pin_basic_acc", exp_acc[0], 70);
        chk("pin_basic_q", exp_q[0], 0);
        run_op(1'b0, 0, 1'b0, 0);

        fill_const(0, -128, -128);
        compute_model();
        chk("pin_pos_sat_acc", exp_acc[0], 32767);
        chk("pin_pos_sat_q", exp_q[0], 127);
        run_op(1'b1, 5, 1'b0, 0);

        fill_const(0, -128, 127);
        compute_model();
        chk("pin_neg_sat_acc", exp_acc[1], -32768);
        chk("pin_neg_sat_q", exp_q[1], -128);
        run_op(1'b0, 2, 1'b1, 0);

        fill_const(-1, 0, 5);
        compute_model();
        chk("pin_bias_acc", exp_acc[2], -16);
        chk("pin_bias_q", exp_q[2], -1);
        run_op(1'b1, 1, 1'b0, 0);

        fill_rand();
        run_op(1'b0, 0, 1'b0, 4);
        fill_const(1, 2, 3);
        run_op(1'b0, 0, 1'b0, 0);

        fill_rand();
        run_op(1'b0, 3, 1'b1, 0);

        for (int i = 0; i < 16; i++) begin
            fill_rand();
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0);
        end

        @(negedge CLKEXT);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (3) @(negedge CLKEXT);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
